// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 32;
  localparam logic [XLEN-1:0]   PC_STEP  = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && (count_r != CNT_ZERO);
  assign do_push_s = push && ((count_r != CNT_DEPTH) || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign full      = (count_r == CNT_DEPTH);
  assign empty     = (count_r == CNT_ZERO);

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observed while the entry is occupied.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst && !flush) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: issues in-order word requests, buffers responses, hands them to decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   outstanding_next_s;
  logic [CW-1:0]   fifo_count_s;
  logic [CW-1:0]   in_flight_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            rsp_keep_s;
  logic            pop_s;
  logic            accept_s;

  // Credit covers both requests still in memory and words already buffered.
  assign in_flight_s    = outstanding_r + fifo_count_s;
  assign inst_valid     = !rst && !fifo_empty_s;
  assign pop_s          = inst_valid && inst_ready;
  assign imem_req_valid = !rst && !redirect_valid && ((in_flight_s < CNT_DEPTH) || pop_s);
  assign imem_req_addr  = fetch_pc_r;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign rsp_keep_s     = imem_rsp_valid && (drop_cnt_r == CNT_ZERO) && !redirect_valid;
  assign fifo_push_s    = rsp_keep_s && (!fifo_full_s || fifo_pop_s);
  assign fifo_pop_s     = pop_s && !redirect_valid;
  assign push_entry_s   = '{inst: imem_rsp_data, pc: rsp_pc_r};
  assign inst           = fifo_empty_s ? NOP_INST : head_s.inst;
  assign inst_pc        = fifo_empty_s ? rsp_pc_r : head_s.pc;

  // Requests still owed a response by memory after this cycle.
  always_comb begin
    outstanding_next_s = outstanding_r;
    case ({accept_s, imem_rsp_valid})
      2'b10:   outstanding_next_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_next_s = outstanding_r - CNT_ONE;
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // Fetch/response PCs and drop accounting; a redirect turns every pending response stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
    end else if (redirect_valid) begin
      fetch_pc_r    <= align_pc(redirect_pc);
      rsp_pc_r      <= align_pc(redirect_pc);
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= outstanding_next_s;
    end else begin
      if (accept_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
      if (imem_rsp_valid) begin
        if (drop_cnt_r != CNT_ZERO) drop_cnt_r <= drop_cnt_r - CNT_ONE;
        else                        rsp_pc_r   <= rsp_pc_r + PC_STEP;
      end
      outstanding_r <= outstanding_next_s;
    end
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (push_entry_s),
    .rdata (head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-level reference model, directed scenarios, then random traffic.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req_ready, imem_rsp_valid, redirect_valid, inst_ready;
  logic [31:0] imem_rsp_data, redirect_pc;
  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst, inst_pc;

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; } pend_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  pend_t pend_q[$];   // model: accepted requests awaiting a response
  ent_t  fifo_q[$];   // model: words buffered for the decoder
  mreq_t mem_q[$];    // environment: memory's pending responses

  logic [31:0] m_fetch;
  int cyc, last_due, lat_min, lat_max, n_acc;
  int n_chk, n_fail;
  bit exp_rv, exp_iv;
  bit s_rst, s_rdy, s_irdy, s_redir;
  logic [31:0] s_rpc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) + 32'h0001_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Apply stimulus on the falling edge and compare DUT outputs with the model.
  task automatic drive_check();
    @(negedge clk);
    rst = s_rst; imem_req_ready = s_rdy; inst_ready = s_irdy;
    redirect_valid = s_redir; redirect_pc = s_rpc;
    if (s_rst) begin mem_q.delete(); last_due = 0; end
    imem_rsp_valid = !s_rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? memf(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_iv = !s_rst && (fifo_q.size() > 0);
    exp_rv = !s_rst && !s_redir &&
             (((pend_q.size() + fifo_q.size()) < DEPTH) || (exp_iv && s_irdy));
    chk("req_valid", imem_req_valid, exp_rv);
    chk("inst_valid", inst_valid, exp_iv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
    if (exp_iv) begin
      chk("inst_pc", inst_pc, fifo_q[0].pc);
      chk("inst", inst, fifo_q[0].inst);
    end
    chk("push_when_full", dut.rsp_keep_s && dut.fifo_full_s && !dut.fifo_pop_s, 1'b0);
  endtask

  // Advance the model and memory through the coming rising edge.
  task automatic advance();
    bit acc, pop;
    pend_t p;
    int k, due;
    acc = exp_rv && s_rdy;
    pop = exp_iv && s_irdy;
    p.addr = 32'h0; p.drop = 1'b1;
    if (s_rst) begin
      m_fetch = RESET_PC; pend_q.delete(); fifo_q.delete();
    end else begin
      if (imem_rsp_valid) begin
        void'(mem_q.pop_front());
        if (pend_q.size() > 0) p = pend_q.pop_front();
      end
      if (s_redir) begin
        m_fetch = {s_rpc[31:2], 2'b00};
        fifo_q.delete();
        foreach (pend_q[i]) pend_q[i].drop = 1'b1;
      end else begin
        if (pop) void'(fifo_q.pop_front());
        if (imem_rsp_valid && !p.drop) fifo_q.push_back('{memf(p.addr), p.addr});
        if (acc) begin
          pend_q.push_back('{m_fetch, 1'b0});
          k = $urandom_range(lat_max, lat_min);
          due = cyc + k;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_q.push_back('{m_fetch, due});
          m_fetch = m_fetch + 32'd4;
          n_acc++;
        end
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic step();
    drive_check();
    advance();
  endtask

  task automatic reset_dut();
    s_rst = 1'b1; s_redir = 1'b0;
    drive_check();
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    advance();
    s_rst = 1'b0;
    n_acc = 0;
  endtask

  // Bounded wait for the first delivered instruction after a redirect.
  task automatic wait_first(input string name, input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive_check();
      if (inst_valid) begin
        found = 1'b1;
        chk({name, "_pc"}, inst_pc, pc);
        chk({name, "_inst"}, inst, memf(pc));
      end
      advance();
    end
    chk({name, "_seen"}, found, 1'b1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_due = 0; n_acc = 0;
    m_fetch = RESET_PC;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    s_rst = 1'b1; s_rdy = 1'b0; s_irdy = 1'b0; s_redir = 1'b0; s_rpc = 32'h0;
    lat_min = 1; lat_max = 1;

    // 1: streaming with single-cycle memory
    reset_dut();
    s_rdy = 1'b1; s_irdy = 1'b1;
    drive_check(); chk("t1_addr0", imem_req_addr, 32'h0); advance();
    drive_check(); chk("t1_addr1", imem_req_addr, 32'h4); advance();
    drive_check(); chk("t1_addr2", imem_req_addr, 32'h8);
    chk("t1_iv", inst_valid, 1'b1); chk("t1_pc0", inst_pc, 32'h0); advance();
    drive_check(); chk("t1_pc1", inst_pc, 32'h4); chk("t1_inst1", inst, memf(32'h4)); advance();

    // 2: decoder stalled from the start
    reset_dut();
    s_rdy = 1'b1; s_irdy = 1'b0;
    repeat (5) step();
    drive_check();
    chk("t2_nacc", n_acc, 32'd2); chk("t2_rv", imem_req_valid, 1'b0); chk("t2_head", inst_pc, 32'h0);
    advance();
    s_irdy = 1'b1;
    drive_check();
    chk("t2_pc0", inst_pc, 32'h0); chk("t2_rv_pop", imem_req_valid, 1'b1); chk("t2_addr8", imem_req_addr, 32'h8);
    advance();
    drive_check(); chk("t2_pc1", inst_pc, 32'h4); advance();

    // 3: memory not ready for five cycles
    reset_dut();
    s_rdy = 1'b0; s_irdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_check(); chk("t3_rv", imem_req_valid, 1'b1); chk("t3_addr", imem_req_addr, 32'h0); advance();
    end
    s_rdy = 1'b1;
    drive_check(); chk("t3_acc_rv", imem_req_valid, 1'b1); chk("t3_acc_addr", imem_req_addr, 32'h0); advance();
    drive_check(); chk("t3_next_addr", imem_req_addr, 32'h4); advance();

    // 4: redirect with two slow requests outstanding
    reset_dut();
    lat_min = 3; lat_max = 3; s_rdy = 1'b1; s_irdy = 1'b1;
    step(); step();
    s_redir = 1'b1; s_rpc = 32'h0000_0100;
    step();
    s_redir = 1'b0;
    wait_first("t4_first", 32'h0000_0100);

    // 5: redirect colliding with a response and a decoder handshake
    reset_dut();
    lat_min = 1; lat_max = 1; s_rdy = 1'b1; s_irdy = 1'b1;
    step(); step();
    s_redir = 1'b1; s_rpc = 32'h0000_0103;
    drive_check(); chk("t5_iv", inst_valid, 1'b1); chk("t5_pc", inst_pc, 32'h0); advance();
    s_redir = 1'b0;
    drive_check();
    chk("t5_iv_after", inst_valid, 1'b0); chk("t5_rv", imem_req_valid, 1'b1); chk("t5_addr", imem_req_addr, 32'h100);
    advance();
    wait_first("t5_first", 32'h0000_0100);

    // 6: reset with work in flight
    reset_dut();
    lat_min = 3; lat_max = 3; s_rdy = 1'b1; s_irdy = 1'b0;
    repeat (4) step();
    s_rst = 1'b1;
    drive_check(); chk("t6_rst_rv", imem_req_valid, 1'b0); chk("t6_rst_iv", inst_valid, 1'b0); advance();
    s_rst = 1'b0;
    drive_check();
    chk("t6_iv", inst_valid, 1'b0); chk("t6_rv", imem_req_valid, 1'b1);
    chk("t6_addr", imem_req_addr, RESET_PC); chk("t6_in_flight", dut.in_flight_s, 32'h0);
    advance();

    // Random traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(99) == 0);
      s_redir = ($urandom_range(19) == 0);
      s_rpc   = $urandom;
      s_rdy   = ($urandom_range(9) < 7);
      s_irdy  = ($urandom_range(9) < 7);
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
